// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register: command opcodes and FSM states.
package shift_reg_pkg;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_LOAD  = 3'd1,
      OP_CLEAR = 3'd2,
      OP_SHL   = 3'd3,
      OP_SHR   = 3'd4,
      OP_ASR   = 3'd5,
      OP_ROTL  = 3'd6,
      OP_ROTR  = 3'd7
   } op_t;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/shift_step.sv
// One-step shift/rotate function; shared by the accept edge and every SHIFT-state edge.
module shift_step
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       op,
   input  logic             ser_in,
   input  logic [WIDTH-1:0] cur,
   output logic [WIDTH-1:0] nxt
);

   always_comb begin
      // NOTE: nxt gets a default before the case so non-shift opcodes cannot infer a latch.
      nxt = cur;
      case (op_t'(op))
         OP_SHL:  nxt = {cur[WIDTH-2:0], ser_in};
         OP_SHR:  nxt = {ser_in, cur[WIDTH-1:1]};
         OP_ASR:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
         OP_ROTL: nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
         OP_ROTR: nxt = {cur[0], cur[WIDTH-1:1]};
         default: nxt = cur;
      endcase
   end

endmodule

// File: rtl/shift_reg_univ.sv
// Word-wide register with complementary outputs, load/clear and multi-cycle
// shift/rotate commands accepted through a valid/ready handshake.
module shift_reg_univ
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [AMT_W-1:0] cmd_amt,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ser_in,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar,
   output logic             busy,
   output logic             done
);

   state_t             state_q, state_d;
   logic [AMT_W-1:0]   cnt_q, cnt_d;
   op_t                op_q, op_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic               done_q, done_d;

   op_t                cmd_op_e;
   op_t                step_op;
   logic [WIDTH-1:0]   step_nxt;
   logic               accept;

   assign cmd_op_e  = op_t'(cmd_op);
   assign cmd_ready = (state_q == IDLE);
   assign accept    = cmd_valid && cmd_ready;

   // In SHIFT the latched opcode drives the stepper; in IDLE the incoming one does.
   assign step_op   = (state_q == SHIFT) ? op_q : cmd_op_e;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .op     (step_op),
      .ser_in (ser_in),
      .cur    (q_q),
      .nxt    (step_nxt)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      q_d     = q_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               case (cmd_op_e)
                  OP_NOP:   done_d = 1'b1;
                  OP_LOAD: begin
                     q_d    = load_data;
                     done_d = 1'b1;
                  end
                  OP_CLEAR: begin
                     q_d    = '0;
                     done_d = 1'b1;
                  end
                  default: begin
                     if (cmd_amt != '0) q_d = step_nxt;
                     if (cmd_amt > AMT_W'(1)) begin
                        cnt_d   = cmd_amt - AMT_W'(1);
                        op_d    = cmd_op_e;
                        state_d = SHIFT;
                     end else begin
                        done_d = 1'b1;
                     end
                  end
               endcase
            end
         end
         SHIFT: begin
            q_d   = step_nxt;
            cnt_d = cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= OP_NOP;
         q_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         q_q     <= q_d;
         done_q  <= done_d;
      end
   end

   assign q     = q_q;
   assign q_bar = ~q_q;
   assign busy  = (state_q == SHIFT);
   assign done  = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ: a behavioural model checked every cycle plus
// hand-computed literal expectations for the key scenarios.
module tb_shift_reg_univ;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [3:0] cmd_amt;
   logic [7:0] load_data;
   logic       ser_in;
   logic [7:0] q;
   logic [7:0] q_bar;
   logic       busy;
   logic       done;

   int total = 0;
   int bad   = 0;

   shift_reg_univ #(.WIDTH(8), .AMT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_amt   (cmd_amt),
      .load_data (load_data),
      .ser_in    (ser_in),
      .q         (q),
      .q_bar     (q_bar),
      .busy      (busy),
      .done      (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [7:0] m_step(input int op, input logic [7:0] v, input logic s);
      logic [7:0] r;
      case (op)
         3: r = (v << 1) | {7'b0, s};
         4: r = (v >> 1) | {s, 7'b0};
         5: r = 8'($signed(v) >>> 1);
         6: r = (v << 1) | (v >> 7);
         7: r = (v >> 1) | (v << 7);
         default: r = v;
      endcase
      return r;
   endfunction

   int         m_left;
   int         m_op;
   logic [7:0] m_q;
   logic [7:0] m_qb;
   logic       m_done;

   assign m_qb = ~m_q;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left <= 0;
         m_op   <= 0;
         m_q    <= 8'h00;
         m_done <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_left > 0) begin
            m_q    <= m_step(m_op, m_q, ser_in);
            m_left <= m_left - 1;
            if (m_left == 1) m_done <= 1'b1;
         end else if (cmd_valid) begin
            case (int'(cmd_op))
               0: m_done <= 1'b1;
               1: begin m_q <= load_data; m_done <= 1'b1; end
               2: begin m_q <= 8'h00;     m_done <= 1'b1; end
               default: begin
                  m_op <= int'(cmd_op);
                  if (cmd_amt != 0) m_q <= m_step(int'(cmd_op), m_q, ser_in);
                  if (cmd_amt > 1) m_left <= int'(cmd_amt) - 1;
                  else             m_done <= 1'b1;
               end
            endcase
         end
      end
   end

   always @(negedge clk) begin
      check("model_q",     q,         m_q);
      check("model_q_bar", q_bar,     m_qb);
      check("model_ready", cmd_ready, (m_left == 0));
      check("model_busy",  busy,      (m_left > 0));
      check("model_done",  done,      m_done);
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [2:0] op, input logic [3:0] amt, input logic [7:0] d,
                       input logic s);
      bit acc;
      bit ok;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_amt   = amt;
      load_data = d;
      ser_in    = s;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         acc = (m_left == 0);
         @(negedge clk);
         if (acc) begin
            ok = 1'b1;
            break;
         end
      end
      cmd_valid = 1'b0;
      if (!ok) check("send_timeout", 0, 1);
   endtask

   task automatic wait_done(output int nb);
      bit ok;
      nb = 0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (m_done) begin
            ok = 1'b1;
            break;
         end
         if (busy) nb++;
         @(negedge clk);
      end
      if (!ok) check("done_timeout", 0, 1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int nb;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_amt   = 4'd0;
      load_data = 8'h00;
      ser_in    = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_q",     q,         8'h00);
      check("rst_q_bar", q_bar,     8'hFF);
      check("rst_ready", cmd_ready, 1);
      check("rst_busy",  busy,      0);
      rst = 1'b0;

      // asynchronous reset mid-cycle
      send(3'd1, 4'd0, 8'h77, 1'b0);
      check("pre_async_q", q, 8'h77);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_q",     q,         8'h00);
      check("async_q_bar", q_bar,     8'hFF);
      check("async_ready", cmd_ready, 1);
      check("async_busy",  busy,      0);
      @(negedge clk);
      rst = 1'b0;

      // LOAD then NOP back-to-back
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd1; load_data = 8'hA5;
      @(negedge clk);
      check("ld_q",     q,         8'hA5);
      check("ld_q_bar", q_bar,     8'h5A);
      check("ld_done",  done,      1);
      check("ld_ready", cmd_ready, 1);
      cmd_op = 3'd0;
      @(negedge clk);
      check("nop_q",     q,         8'hA5);
      check("nop_done",  done,      1);
      check("nop_ready", cmd_ready, 1);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("nop_done_low", done, 0);

      // multi-cycle SHL with a LOAD held during busy
      send(3'd1, 4'd0, 8'h81, 1'b0);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd3; cmd_amt = 4'd3; ser_in = 1'b1;
      @(negedge clk);
      check("shl_s1_q",     q,         8'h03);
      check("shl_s1_busy",  busy,      1);
      check("shl_s1_ready", cmd_ready, 0);
      check("shl_s1_done",  done,      0);
      cmd_op = 3'd1; load_data = 8'h55;
      @(negedge clk);
      check("shl_s2_q",    q,    8'h07);
      check("shl_s2_busy", busy, 1);
      check("shl_s2_done", done, 0);
      @(negedge clk);
      check("shl_s3_q",     q,         8'h0F);
      check("shl_s3_busy",  busy,      0);
      check("shl_s3_done",  done,      1);
      check("shl_s3_ready", cmd_ready, 1);
      @(negedge clk);
      check("held_ld_q",    q,    8'h55);
      check("held_ld_done", done, 1);
      cmd_valid = 1'b0;

      // arithmetic and rotate
      send(3'd1, 4'd0, 8'h90, 1'b0);
      send(3'd5, 4'd2, 8'h00, 1'b0);
      wait_done(nb);
      check("asr2_q", q, 8'hE4);
      send(3'd1, 4'd0, 8'h81, 1'b0);
      send(3'd7, 4'd9, 8'h00, 1'b0);
      wait_done(nb);
      check("rotr9_q", q, 8'hC0);

      // boundary amounts
      send(3'd4, 4'd0, 8'h00, 1'b1);
      check("shr0_q",    q,    8'hC0);
      check("shr0_done", done, 1);
      send(3'd1, 4'd0, 8'hFF, 1'b0);
      send(3'd4, 4'd15, 8'h00, 1'b0);
      wait_done(nb);
      check("shr15_q",    q,  8'h00);
      check("shr15_busy", nb, 14);

      // reset in the middle of a long rotate
      send(3'd1, 4'd0, 8'h01, 1'b0);
      send(3'd6, 4'd10, 8'h00, 1'b0);
      repeat (3) @(negedge clk);
      check("rotl4_q", q, 8'h10);
      #1 rst = 1'b1;
      #1;
      check("midrst_q",     q,         8'h00);
      check("midrst_busy",  busy,      0);
      check("midrst_ready", cmd_ready, 1);
      check("midrst_done",  done,      0);
      @(negedge clk);
      check("midrst_done2", done, 0);
      rst = 1'b0;
      cmd_valid = 1'b1; cmd_op = 3'd1; load_data = 8'h3C;
      @(negedge clk);
      check("post_rst_q",    q,    8'h3C);
      check("post_rst_done", done, 1);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal register with asynchronous active-high reset: a WIDTH-bit register with complementary outputs, parallel load, clear, and multi-cycle shift/rotate commands issued through a valid/ready handshake. It generalises the team's single-bit D flip-flop with complementary output into a word-wide storage and shifting element. It serves as the building block for serialisers, scramblers and alignment logic in the datapath.

## Interface
- WIDTH, 8, register width in bits (≥2)
- AMT_W, 4, width of the shift-amount field
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command this cycle
- cmd_op  in  3  opcode: 0 NOP, 1 LOAD, 2 CLEAR, 3 SHL, 4 SHR, 5 ASR, 6 ROTL, 7 ROTR
- cmd_amt  in  AMT_W  number of single-bit steps for opcodes 3–7
- load_data  in  WIDTH  parallel data for LOAD
- ser_in  in  1  serial fill bit for SHL (into bit 0) and SHR (into bit WIDTH-1), sampled on every step edge
- q  out  WIDTH  register contents
- q_bar  out  WIDTH  always exactly ~q, including during reset
- busy  out  1  multi-cycle shift in progress
- done  out  1  one-cycle pulse: the accepted command has fully completed

## Operation
- Reset (async assert): q=0, q_bar=all ones, cmd_ready=1, busy=0, done=0, FSM→IDLE, step counter=0. Reset asserted mid-shift aborts the command; no done pulse is produced for it.
- FSM states: IDLE and SHIFT.
- Accept: a command is accepted on a rising edge with cmd_valid && cmd_ready. cmd_ready = (state==IDLE).
- In IDLE, on accept:
  - NOP: q unchanged; done=1 next cycle.
  - LOAD: q←load_data; done=1 next cycle.
  - CLEAR: q←0; done=1 next cycle.
  - Shift opcodes with cmd_amt=0: q unchanged; done=1 next cycle.
  - Shift opcodes with cmd_amt=1: one step applied at the accept edge; done=1 next cycle; stay in IDLE.
  - Shift opcodes with cmd_amt>1: one step applied at the accept edge; counter←cmd_amt-1; opcode latched; state→SHIFT.
- In SHIFT, each edge applies one step and decrements the counter. On the edge where the counter goes 1→0, state→IDLE and done=1 next cycle.
- Step definitions:
  - SHL: {q[W-2:0],ser_in}
  - SHR: {ser_in,q[W-1:1]}
  - ASR: {q[W-1],q[W-1:1]}
  - ROTL: {q[W-2:0],q[W-1]}
  - ROTR: {q[0],q[W-1:1]}
- cmd_amt may exceed WIDTH. Steps continue regardless: the result is all fill bits for SHL/SHR, sign fill for ASR, and amt mod WIDTH rotation for ROTL/ROTR.
- cmd_valid while busy is not accepted. The issuer must hold its command; cmd_op, cmd_amt and load_data are sampled only at the accept edge.
- done and cmd_ready are both high in the cycle after completion, so back-to-back commands are allowed with no idle cycle.

## Timing
- LOAD, CLEAR, NOP, amt 0 and amt 1: q valid one cycle after the accept edge; throughput one command per cycle.
- Shift with amt=N≥1: q updates on N consecutive edges starting at the accept edge. busy=1 and cmd_ready=0 for N-1 cycles. done is high in the cycle following the Nth edge.
- All outputs are registered except cmd_ready (decoded from state) and q_bar (inverter on q).
- There is no combinational path from any input to any output.

## Structure
- Package shift_reg_pkg holds:
  - the opcode enum (op_t) with the values listed above;
  - the state enum (IDLE, SHIFT).
- Sub-module shift_step: purely combinational, parameter WIDTH; inputs op, ser_in, cur; output nxt. Implements the one-step function and is reused by the top for both the accept edge and SHIFT-state edges.
- Top level contains the FSM, the step counter, the latched opcode and the q register.

## Test plan
- Reset: assert rst asynchronously mid-cycle → q=0x00, q_bar=0xFF, cmd_ready=1, busy=0 immediately, without waiting for a clock edge.
- Load then NOP back-to-back: LOAD 0xA5, then NOP on the next cycle → q=0xA5 and q_bar=0x5A one cycle after the first accept; two done pulses on consecutive cycles; cmd_ready never drops.
- Multi-cycle shift: from q=0x81, SHL amt=3 with ser_in=1 → q sequence 0x03, 0x07, 0x0F on consecutive edges; busy high for 2 cycles; exactly one done pulse, one cycle after the third step; a cmd_valid LOAD held during busy is accepted only in the done cycle.
- Arithmetic and rotate: from q=0x90, ASR amt=2 → 0xE4. From q=0x81, ROTR amt=9 (WIDTH=8) → 0xC0.
- Boundary amounts: SHR amt=0 → q unchanged, done next cycle. From q=0xFF, SHR amt=15 with ser_in=0 → q=0x00, busy for 14 cycles.
- Reset mid-shift: ROTL amt=10 started, rst pulsed after 4 steps → state IDLE, q=0, no done pulse; a new LOAD 0x3C accepted on the first edge after reset release yields q=0x3C.
